// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, FSM state type and default tuning for the memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int WORD_LEN = 32;
  localparam int MAX_D_STREAK_DEF = 4;
  localparam int TIMEOUT_DEF = 64;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arb_state_t;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: loadable down-counter; expired is high once the count has run out.
module mem_arb_timer #(
  parameter int TIMEOUT = 64,
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rstn) cnt <= '0;
    else if (load) cnt <= TW'(TIMEOUT - 1);
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and MEM stage,
// data first with a bounded streak so a waiting fetch cannot starve.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int SW = $clog2(MAX_D_STREAK + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                if_req,
  input  logic [WORD_LEN-1:0] if_addr,
  input  logic                if_flush,
  output logic                if_valid,
  output logic [WORD_LEN-1:0] if_rdata,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_valid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic                mem_ack,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                timeout_err
);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);
  arb_state_t state;
  logic [SW-1:0] streak;
  logic flush_q, fetch_ok, grant_d, grant_i, busy, expired;
  assign busy = state == BUSY_I || state == BUSY_D;
  assign fetch_ok = if_req && !if_flush;
  assign grant_d = state == IDLE && d_req && !(fetch_ok && streak == SMAX);
  assign grant_i = state == IDLE && fetch_ok && !grant_d;
  assign if_stall = if_req && !if_valid;
  assign d_stall = d_req && !d_valid;
  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rstn(rstn),
    .load(grant_d || grant_i),
    .en(busy),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      streak <= '0;
      flush_q <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_valid <= 1'b0;
      d_valid <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
      timeout_err <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid <= 1'b0;
      if (!if_req) streak <= '0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state <= BUSY_D;
            mem_req <= 1'b1;
            mem_we <= d_we;
            mem_addr <= d_addr;
            mem_wdata <= d_wdata;
            if (if_req && streak != SMAX) streak <= streak + 1'b1;
          end else if (grant_i) begin
            state <= BUSY_I;
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= if_addr;
            mem_wdata <= '0;
            streak <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (state == BUSY_I && if_flush) flush_q <= 1'b1;
          if (mem_ack) begin
            state <= RESP;
            mem_req <= 1'b0;
            if (state == BUSY_I) begin
              if_rdata <= mem_rdata;
              if_valid <= !(flush_q || if_flush);
            end else begin
              d_rdata <= mem_we ? '0 : mem_rdata;
              d_valid <= 1'b1;
            end
          end else if (expired) begin
            // abandoned access: no pulse, so the requester keeps stalling
            state <= IDLE;
            mem_req <= 1'b0;
            timeout_err <= 1'b1;
            flush_q <= 1'b0;
          end
        end
        RESP: begin
          state <= IDLE;
          flush_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench with a latency-programmable memory model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic if_valid, if_stall, d_valid, d_stall, mem_req, mem_we, timeout_err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  int checks = 0, errors = 0;
  int ack_lat = 0, wcnt = 0, iv_cnt = 0, dv_cnt = 0;
  logic [64:0] exp_g[$];
  logic [31:0] exp_i[$], exp_d[$];

  mem_port_arbiter dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : a ^ 32'hCAFE0000;
  endfunction

  function automatic logic [64:0] gkey(input logic we, input logic [31:0] a, input logic [31:0] wd);
    return {we, a, we ? wd : 32'h0};
  endfunction

  // memory responder plus output scoreboard; outputs are stable at negedge
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req && ack_lat >= 0) begin
      if (wcnt == ack_lat) begin
        mem_ack = 1'b1;
        mem_rdata = mem_model(mem_addr);
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
    if (mem_ack) begin
      if (exp_g.size() == 0) chk("grant_extra", 65'(exp_g.size()), 65'd1);
      else chk("grant", gkey(mem_we, mem_addr, mem_wdata), exp_g.pop_front());
    end
    if (if_valid) begin
      iv_cnt++;
      if (exp_i.size() == 0) chk("if_valid_extra", 65'(exp_i.size()), 65'd1);
      else chk("if_rdata", 65'(if_rdata), 65'(exp_i.pop_front()));
    end
    if (d_valid) begin
      dv_cnt++;
      if (exp_d.size() == 0) chk("d_valid_extra", 65'(exp_d.size()), 65'd1);
      else chk("d_rdata", 65'(d_rdata), 65'(exp_d.pop_front()));
    end
  end

  task automatic wait_valid(input bit is_d, input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(is_d ? d_valid : if_valid) && cyc < 300);
    chk(tag, 65'(is_d ? d_valid : if_valid), 65'd1);
  endtask

  task automatic wait_mem_req(input string tag);
    int n = 0;
    while (!mem_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 65'(mem_req), 65'd1);
  endtask

  initial begin
    int cyc, dv0, iv0, hi;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 65'(mem_req), 65'd0);
    chk("rst_valids", 65'({if_valid, d_valid}), 65'd0);
    chk("rst_timeout_err", 65'(timeout_err), 65'd0);
    chk("rst_rdata", 65'({if_rdata, d_rdata}), 65'd0);
    rstn = 1'b1;
    @(negedge clk);

    // single fetch, memory acks one cycle after mem_req
    ack_lat = 1;
    exp_g.push_back(gkey(1'b0, 32'h100, 32'h0));
    exp_i.push_back(32'hDEADBEEF);
    if_addr = 32'h100;
    if_req = 1'b1;
    #1 chk("fetch_stall_on", 65'(if_stall), 65'd1);
    wait_valid(1'b0, "fetch_valid", cyc);
    chk("fetch_latency", 65'(cyc), 65'd3);
    chk("fetch_stall_at_valid", 65'(if_stall), 65'd0);
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch_pulse_one_cycle", 65'(if_valid), 65'd0);
    chk("fetch_rdata_hold", 65'(if_rdata), 65'(32'hDEADBEEF));
    chk("fetch_stall_after", 65'(if_stall), 65'd0);

    // simultaneous store and fetch: store granted first
    ack_lat = 0;
    exp_g.push_back(gkey(1'b1, 32'h40, 32'h12345678));
    exp_g.push_back(gkey(1'b0, 32'h200, 32'h0));
    exp_d.push_back(32'h0);
    exp_i.push_back(mem_model(32'h200));
    d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_req = 1'b1;
    if_addr = 32'h200; if_req = 1'b1;
    iv0 = iv_cnt;
    wait_valid(1'b1, "store_valid", cyc);
    chk("store_before_fetch", 65'(iv_cnt - iv0), 65'd0);
    chk("store_latency", 65'(cyc), 65'd2);
    d_req = 1'b0;
    wait_valid(1'b0, "fetch2_valid", cyc);
    if_req = 1'b0;
    @(negedge clk);

    // data held continuously with a waiting fetch: 4 data, 1 fetch, data again
    d_we = 1'b0; d_addr = 32'h44; d_req = 1'b1;
    if_addr = 32'h208; if_req = 1'b1;
    repeat (4) begin
      exp_g.push_back(gkey(1'b0, 32'h44, 32'h0));
      exp_d.push_back(mem_model(32'h44));
    end
    exp_g.push_back(gkey(1'b0, 32'h208, 32'h0));
    exp_i.push_back(mem_model(32'h208));
    exp_g.push_back(gkey(1'b0, 32'h44, 32'h0));
    exp_d.push_back(mem_model(32'h44));
    dv0 = dv_cnt;
    wait_valid(1'b0, "streak_fetch_valid", cyc);
    chk("streak_data_count", 65'(dv_cnt - dv0), 65'd4);
    if_req = 1'b0;
    wait_valid(1'b1, "streak_data_resume", cyc);
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    // flush during BUSY_I: access completes, no if_valid
    ack_lat = 3;
    exp_g.push_back(gkey(1'b0, 32'h300, 32'h0));
    if_addr = 32'h300; if_req = 1'b1;
    iv0 = iv_cnt;
    wait_mem_req("flush_mem_req");
    if_flush = 1'b1;
    @(negedge clk);
    if_flush = 1'b0; if_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("flush_no_valid", 65'(iv_cnt - iv0), 65'd0);
    chk("flush_idle", 65'(mem_req), 65'd0);
    chk("flush_grant_done", 65'(exp_g.size()), 65'd0);

    // no ack: timeout after 64 cycles of mem_req
    ack_lat = -1;
    d_we = 1'b0; d_addr = 32'h80; d_req = 1'b1;
    wait_mem_req("to_mem_req");
    hi = 0;
    while (mem_req && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    chk("to_mem_req_cycles", 65'(hi), 65'd64);
    chk("to_err_set", 65'(timeout_err), 65'd1);
    chk("to_d_stall", 65'(d_stall), 65'd1);
    chk("to_no_valid", 65'(d_valid), 65'd0);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 65'(timeout_err), 65'd1);
    chk("to_regrant_busy", 65'(mem_req), 65'd1);

    // reset mid BUSY_D, then a normal fetch
    rstn = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("rst2_mem_req", 65'(mem_req), 65'd0);
    chk("rst2_valids", 65'({if_valid, d_valid}), 65'd0);
    chk("rst2_timeout_err", 65'(timeout_err), 65'd0);
    rstn = 1'b1;
    ack_lat = 0;
    exp_g.push_back(gkey(1'b0, 32'h100, 32'h0));
    exp_i.push_back(32'hDEADBEEF);
    if_addr = 32'h100; if_req = 1'b1;
    wait_valid(1'b0, "post_rst_fetch", cyc);
    chk("post_rst_latency", 65'(cyc), 65'd2);
    if_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("end_grant_q", 65'(exp_g.size()), 65'd0);
    chk("end_if_q", 65'(exp_i.size()), 65'd0);
    chk("end_d_q", 65'(exp_d.size()), 65'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-port, variable-latency unified memory shared by the instruction-fetch stage and the MEM stage of the 5-stage pipeline.
- Arbitrates requests from the two requesters and drives the memory req/ack handshake.
- Returns read data to the winning requester and provides per-requester stall signals to the hazard/pipeline-register enables.
- MEM-stage read data returned here feeds the MEM/WB register's memory-read-value input.

Parameters:
WORD_LEN, 32 (from defines), data and address width
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is waiting
TIMEOUT, 64, cycles to wait for mem_ack before aborting

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
if_req  input  1  fetch request, held until if_valid
if_addr  input  WORD_LEN  fetch address
if_flush  input  1  discard the outstanding fetch (branch taken)
if_valid  output  1  one-cycle pulse; if_rdata valid
if_rdata  output  WORD_LEN  fetched instruction
if_stall  output  1  if_req && !if_valid
d_req  input  1  data request, held until d_valid
d_we  input  1  1 = store, 0 = load
d_addr  input  WORD_LEN  data address
d_wdata  input  WORD_LEN  store data
d_valid  output  1  one-cycle pulse; access complete
d_rdata  output  WORD_LEN  load data (0 for stores)
d_stall  output  1  d_req && !d_valid
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  write enable
mem_addr  output  WORD_LEN  address
mem_wdata  output  WORD_LEN  write data
mem_ack  input  1  completion; mem_rdata valid same cycle
mem_rdata  input  WORD_LEN  read data
timeout_err  output  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset is synchronous: rstn low at a posedge forces state IDLE, clears all outputs, latches, the streak counter and the timeout counter. Reset mid-transaction drops mem_req the next cycle; the in-flight access is abandoned.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, arbitration on registered inputs:
  - Data wins if d_req=1, unless if_req=1 and streak==MAX_D_STREAK; fetch wins then.
  - Fetch wins if only if_req=1.
  - On a grant: latch addr/we/wdata, go to BUSY_I or BUSY_D.
  - streak increments on a data grant while if_req=1; resets to 0 on any fetch grant or when if_req=0.
- BUSY_x:
  - mem_req=1; mem_addr/mem_we/mem_wdata come from the latches and are stable until ack. mem_we=0 in BUSY_I.
  - Timeout counter increments each cycle.
  - mem_ack=1: capture mem_rdata (0 for store) into x_rdata, go to RESP.
  - Counter reaches TIMEOUT-1 with no ack: set timeout_err, drop mem_req, go to IDLE, no valid pulse (requester keeps stalling).
- RESP:
  - mem_req=0; x_valid=1 for exactly this cycle; next state IDLE.
  - Requester must deassert or change its request in the cycle after valid.
  - No arbitration occurs in RESP, so a held request is never double-served.
- Latency: request seen at edge N -> mem_req from N+1 -> ack at edge N+1+k -> valid during the cycle after. Minimum is 2 cycles from request to valid with a zero-wait memory.
- if_flush:
  - In BUSY_I: the memory transaction completes (no abort); a flush flag suppresses if_valid in RESP.
  - In IDLE with if_req: that fetch is not granted this cycle.
  - The flag clears on leaving RESP.
- if_rdata and d_rdata hold their last value between pulses.
- Simultaneous d_req and if_req with streak<MAX: data is granted first, fetch next.

Decomposition:
- Package defines: WORD_LEN; enum arb_state_t {IDLE, BUSY_I, BUSY_D, RESP}; MAX_D_STREAK_DEF; TIMEOUT_DEF.
- One sub-module, mem_arb_timer: the loadable timeout down-counter with expiry flag.
- Arbitration and FSM stay in the top module.

Test Plan:
- Fetch only, if_addr=0x100, ack 1 cycle after mem_req with rdata 0xDEADBEEF -> mem_addr=0x100, mem_we=0, single if_valid pulse with if_rdata=0xDEADBEEF, if_stall low after it.
- d_req store (addr 0x40, wdata 0x12345678) and if_req in the same cycle -> data granted first with mem_we=1, d_valid pulses, d_rdata=0; then fetch granted.
- d_req held continuously with if_req pending, zero-wait memory -> exactly 4 data grants, then 1 fetch grant, then data resumes.
- if_flush asserted during BUSY_I, ack after 3 cycles -> mem transaction completes, no if_valid pulse, state returns to IDLE.
- mem_ack never asserted -> mem_req drops after 64 cycles, timeout_err=1 and stays 1, d_stall stays high.
- rstn low for one cycle during BUSY_D -> next cycle mem_req=0, all valids 0, timeout_err=0, and the next request arbitrates normally.
